ps2_host_tx: RTL
================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 9600, clk_sys cycles to hold PS/2 clock low before the start bit (100 us at 96 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1440000, max clk_sys cycles between device clock falling edges or before ack (15 ms).
REQ-003 SHALL have port clk_sys  in  1  system clock; all logic on posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port tx_data  in  8  byte to send to the keyboard, e.g. ED = set LEDs, then the LED mask.
REQ-006 SHALL have port tx_strobe  in  1  one-cycle request; tx_data is captured in the same cycle.
REQ-007 SHALL have port busy  out  1  high from the accepted strobe until done or error.
REQ-008 SHALL have port done  out  1  one-cycle pulse when the device acks.
REQ-009 SHALL have port error  out  1  one-cycle pulse on timeout or missing ack.
REQ-010 SHALL have ports ps2_clk_i, ps2_dat_i  in  1  each, raw PS/2 line levels.
REQ-011 SHALL have ports ps2_clk_oe, ps2_dat_oe  out  1  each; 1 = drive the line low (open collector), 0 = release.

Function
REQ-012 SHALL synchronize ps2_clk_i and ps2_dat_i through 2 flops and detect clock falling edges on the synchronized clock.
REQ-013 SHALL have states IDLE, INHIBIT, START, SHIFT, ACK and WAIT_IDLE.
REQ-014 SHALL, in IDLE with tx_strobe=1, latch tx_data, compute odd parity (~^tx_data), set busy, and go to INHIBIT.
REQ-015 SHALL ignore tx_strobe while busy=1; the latched byte stays unchanged.
REQ-016 SHALL, in INHIBIT, hold ps2_clk_oe=1 for exactly INHIBIT_CYC cycles, then set ps2_dat_oe=1 (start bit) and go to START.
REQ-017 SHALL, in START, keep ps2_clk_oe=1 for 1 further cycle with data low, then release clock (ps2_clk_oe=0) and go to SHIFT with bit count 0.
REQ-018 SHALL, in SHIFT, on each synchronized clock falling edge drive the next bit, where driving bit b means ps2_dat_oe=~b:
 - edges 1-8: D0..D7, LSB first;
 - edge 9: parity;
 - edge 10: release data (stop bit=1), then go to ACK.
REQ-019 SHALL, in ACK, sample synchronized data on the next falling edge: 0 = ack, go to WAIT_IDLE; 1 = pulse error, go to IDLE.
REQ-020 SHALL, in WAIT_IDLE, wait until synchronized clock and data are both 1, then pulse done, clear busy, and go to IDLE.
REQ-021 SHALL run a timeout counter in SHIFT, ACK and WAIT_IDLE, cleared on every falling edge; on reaching TIMEOUT_CYC it SHALL release both lines, pulse error, clear busy, and go to IDLE.
REQ-022 SHALL pulse done and error in the same cycle busy falls; the two SHALL never be high together.
REQ-023 SHALL NOT let a falling edge in IDLE, INHIBIT or START advance the bit count.

Reset
REQ-024 SHALL, on reset (including mid-transfer), set state IDLE, busy=0, done=0, error=0, ps2_clk_oe=0, ps2_dat_oe=0, and clear all counters, effective the cycle after reset is sampled.
REQ-025 SHALL NOT generate a done or error pulse as a result of reset.

Configuration
REQ-026 SHALL, when macro PS2_HOST_TX_FILTER_EN is defined, accept a clock level change only after 8 consecutive equal synchronized samples, adding 8 cycles of edge latency.
REQ-027 SHALL, when PS2_HOST_TX_FILTER_EN is undefined, use the raw 2-flop synchronized clock; edge latency is 2 cycles.

Verification
REQ-028 SHALL cover: INHIBIT_CYC=20, strobe with tx_data=ED -> clk_oe low 20 cycles, then start bit; device model sees bits 1,0,1,1,0,1,1,1, parity 1, stop 1; model acks -> done=1 once, busy=0.
REQ-029 SHALL cover: tx_data=00 -> parity bit 1; tx_data=01 -> parity bit 0.
REQ-030 SHALL cover: device model stops clocking after edge 4, TIMEOUT_CYC=1000 -> error pulse 1000 cycles after edge 4, both oe=0.
REQ-031 SHALL cover: device model gives no ack (data high at edge 11) -> error=1, done never asserted.
REQ-032 SHALL cover: reset asserted at edge 6 -> both oe=0 and busy=0 next cycle, no done/error; a new strobe with 02 then completes normally.
REQ-033 SHALL cover: second strobe with 55 during a busy transfer of ED -> ED sent intact, 55 dropped.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter.
// Pulls the PS/2 clock low to request the bus and drives the start bit.
// It then shifts out D0..D7, odd parity and the stop bit on device clock
// falling edges. Finally it checks the device ack and waits for the bus to
// return to idle.
// Optional build macro PS2_HOST_TX_FILTER_EN: when defined, the synchronized
// PS/2 clock is debounced. A level change is accepted only after 8
// consecutive equal samples.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 9600,
    parameter int TIMEOUT_CYC = 1440000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_strobe,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        START     = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    // Synchronizers and edge detection
    logic [1:0] r_clk_sync;
    logic [1:0] r_dat_sync;
    logic       r_clk_prev;
    logic       w_clk_s;
    logic       w_dat_s;
    logic       w_fall;

    // Two-flop synchronizers for the raw PS/2 line levels (idle level is 1)
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk_i};
            r_dat_sync <= {r_dat_sync[0], ps2_dat_i};
        end
    end

`ifdef PS2_HOST_TX_FILTER_EN
    logic [2:0] r_filt_cnt;
    logic       r_clk_filt;

    // Debounce: adopt a new clock level after 8 consecutive differing samples
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_filt_cnt <= 3'd0;
            r_clk_filt <= 1'b1;
        end else if (r_clk_sync[1] != r_clk_filt) begin
            if (r_filt_cnt == 3'd7) begin
                r_filt_cnt <= 3'd0;
                r_clk_filt <= r_clk_sync[1];
            end else begin
                r_filt_cnt <= r_filt_cnt + 3'd1;
            end
        end else begin
            r_filt_cnt <= 3'd0;
        end
    end

    assign w_clk_s = r_clk_filt;
`else
    assign w_clk_s = r_clk_sync[1];
`endif

    assign w_dat_s = r_dat_sync[1];
    assign w_fall  = r_clk_prev & ~w_clk_s;

    // Previous clock level, used to detect falling edges
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_prev <= w_clk_s;
        end
    end

    // State and datapath registers
    state_t        r_state;
    logic [7:0]    r_data;
    logic          r_par;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic          r_clk_oe;
    logic          r_dat_oe;
    logic [IW-1:0] r_inh_cnt;
    logic [3:0]    r_bit_cnt;
    logic [TW-1:0] r_to_cnt;

    state_t        w_state_nxt;
    logic [7:0]    w_data_nxt;
    logic          w_par_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_error_nxt;
    logic          w_clk_oe_nxt;
    logic          w_dat_oe_nxt;
    logic [IW-1:0] w_inh_nxt;
    logic [3:0]    w_bit_nxt;
    logic [TW-1:0] w_to_nxt;
    logic          w_to_hit;

    assign w_to_hit = (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    // Register all FSM state and outputs; reset aborts any transfer silently
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= IDLE;
            r_data    <= 8'h00;
            r_par     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_dat_oe  <= 1'b0;
            r_inh_cnt <= '0;
            r_bit_cnt <= 4'd0;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_data    <= w_data_nxt;
            r_par     <= w_par_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
            r_clk_oe  <= w_clk_oe_nxt;
            r_dat_oe  <= w_dat_oe_nxt;
            r_inh_cnt <= w_inh_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_to_cnt  <= w_to_nxt;
        end
    end

    // Next-state and next-output logic; pulses default low every cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_data_nxt   = r_data;
        w_par_nxt    = r_par;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_error_nxt  = 1'b0;
        w_clk_oe_nxt = r_clk_oe;
        w_dat_oe_nxt = r_dat_oe;
        w_inh_nxt    = r_inh_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_to_nxt     = r_to_cnt;

        case (r_state)
            IDLE: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                if (tx_strobe) begin
                    w_data_nxt   = tx_data;
                    w_par_nxt    = ~^tx_data;
                    w_busy_nxt   = 1'b1;
                    w_inh_nxt    = '0;
                    w_bit_nxt    = 4'd0;
                    w_to_nxt     = '0;
                    w_clk_oe_nxt = 1'b1;
                    w_state_nxt  = INHIBIT;
                end else begin
                    w_busy_nxt = 1'b0;
                end
            end

            INHIBIT: begin
                if (r_inh_cnt == IW'(INHIBIT_CYC - 1)) begin
                    w_dat_oe_nxt = 1'b1;
                    w_state_nxt  = START;
                end else begin
                    w_inh_nxt = r_inh_cnt + IW'(1);
                end
            end

            START: begin
                // Data is already low; release the clock so the device clocks
                w_clk_oe_nxt = 1'b0;
                w_bit_nxt    = 4'd0;
                w_to_nxt     = '0;
                w_state_nxt  = SHIFT;
            end

            SHIFT: begin
                if (w_fall) begin
                    w_to_nxt  = '0;
                    w_bit_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt < 4'd8) begin
                        w_dat_oe_nxt = ~r_data[r_bit_cnt[2:0]];
                    end else if (r_bit_cnt == 4'd8) begin
                        w_dat_oe_nxt = ~r_par;
                    end else begin
                        w_dat_oe_nxt = 1'b0;
                        w_state_nxt  = ACK;
                    end
                end else if (w_to_hit) begin
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b0;
                    w_error_nxt  = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = IDLE;
                end else begin
                    w_to_nxt = r_to_cnt + TW'(1);
                end
            end

            ACK: begin
                if (w_fall) begin
                    w_to_nxt = '0;
                    if (!w_dat_s) begin
                        w_state_nxt = WAIT_IDLE;
                    end else begin
                        w_error_nxt = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end else if (w_to_hit) begin
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b0;
                    w_error_nxt  = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = IDLE;
                end else begin
                    w_to_nxt = r_to_cnt + TW'(1);
                end
            end

            WAIT_IDLE: begin
                if (w_clk_s && w_dat_s) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (w_fall) begin
                    w_to_nxt = '0;
                end else if (w_to_hit) begin
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b0;
                    w_error_nxt  = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = IDLE;
                end else begin
                    w_to_nxt = r_to_cnt + TW'(1);
                end
            end

            default: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
                w_state_nxt  = IDLE;
            end
        endcase
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;

endmodule
